nv_ram_rwsp_fifo_ctrl: RTL and testbench
========================================

# nv_ram_rwsp_fifo_ctrl

Valid/ready FIFO controller that drives an `nv_ram_rwsp_256x257`-class RAM: one write port, a two-stage read port (`re` registers the address, `ore` registers the data), and `pwrbus_ram_pd`. It owns the pointers, occupancy and read-pipeline sequencing, so client logic sees a plain push/pop FIFO with full write and read throughput. It sits between a producer and consumer in the same clock domain. The RAM instance is external to this block.

## Interface
- `DEPTH`, 256: RAM entries. Must be a power of two.
- `AW`, 8: address width, log2(`DEPTH`).
- `DW`, 257: payload width.
- `clk` in 1: core clock; also clocks the RAM.
- `rst` in 1: reset. Asynchronous, active-high.
- `wr_pvld` in 1: write payload valid.
- `wr_prdy` out 1: write ready.
- `wr_pd` in `DW`: write payload.
- `rd_pvld` out 1: read payload valid.
- `rd_prdy` in 1: read ready.
- `rd_pd` out `DW`: read payload, driven directly from `ram_dout`.
- `occupancy` out `AW+1`: entries accepted and not yet popped, range 0..`DEPTH`+1.
- `ram_we`, `ram_wa[AW-1:0]`, `ram_di[DW-1:0]` out: RAM write port.
- `ram_re`, `ram_ra[AW-1:0]` out: RAM read-address stage.
- `ram_ore` out 1: RAM output-register enable.
- `ram_dout` in `DW`: RAM output register.
- `pwrbus_ram_pd` in 32: passed through to `ram_pwrbus_ram_pd` out 32 unchanged.

## Operation

**Write path**
- `wr_prdy` = !`rst` && (`used` != `DEPTH`). It is a function of state only, with no combinational path from `rd_prdy`.
- Accept = `wr_pvld` && `wr_prdy`.
- On accept: `ram_we`=1, `ram_wa`=`wr_ptr`, `ram_di`=`wr_pd`, and `wr_ptr` increments modulo `DEPTH`.

**State**
- `wr_ptr`, `rd_ptr`: `AW` bits.
- `used`: `AW+1` bits. Counts entries written to RAM and not yet moved into the RAM output register.
- `avail`: `AW+1` bits. Counts entries written and not yet issued to the address stage.
- `p1_vld`: the RAM address register holds a live address.
- `out_vld`: the RAM output register holds live data.

**Read pipeline**
- `ram_ore` = `p1_vld` && (!`out_vld` || `rd_prdy`). This is the advance from the address stage to the output stage.
- `ram_re` = (`avail` != 0) && (!`p1_vld` || `ram_ore`). This is the issue; `ram_ra` = `rd_ptr`.
- On issue: `rd_ptr` increments modulo `DEPTH` and `avail` decrements.
- While `p1_vld` && !`ram_ore`: `ram_re`=0. This holds the RAM address register, so `M[ra_d]` stays stable.
- `p1_vld` next = `ram_re` || (`p1_vld` && !`ram_ore`).
- `out_vld` next = `ram_ore` || (`out_vld` && !`rd_prdy`).
- `rd_pvld` = `out_vld`; `rd_pd` = `ram_dout`. Payload is held stable while `rd_pvld` && !`rd_prdy`.

**Slot release and counters**
- A slot is freed (`used` decrements) only on `ram_ore`, i.e. when its data is captured in the RAM output register. A slot in the address stage is never overwritten.
- `used` and `avail` update with simultaneous increment and decrement in the same cycle; the net change may be 0.
- `occupancy` = `used` + `out_vld`. Total capacity is `DEPTH`+1 (RAM plus output register).

**Boundaries**
- Full: `used`==`DEPTH` forces `wr_prdy`=0. A free (`ram_ore`) in the same cycle does not admit a write until the next cycle.
- Empty (`avail`==0): no `ram_re`. Pipeline contents drain normally.
- Pointer wrap from 255 to 0 is seamless.
- Simultaneous accept and issue on an empty FIFO: issue does not happen. `avail` reads 0 in that cycle, so the new entry is issued the next cycle. This prevents reading an address in the same cycle it is written.

**Reset**
- While `rst` is high: pointers, `used`, `avail`, `p1_vld` and `out_vld` are 0.
- Outputs during reset: `rd_pvld`=0, `wr_prdy`=0, `ram_we`=`ram_re`=`ram_ore`=0, `occupancy`=0.
- Reset mid-operation discards all in-flight data immediately. RAM contents are not cleared and are never read stale, because `avail` restarts at 0.

## Timing
- Write accepted at edge W.
  - W+1: `ram_re`=1.
  - W+2: `ram_ore`=1.
  - `rd_pvld`=1 from W+2. First data is visible 2 cycles after acceptance.
- Steady state with `rd_prdy`=1 and `avail`>0: one pop per cycle.
- With `wr_pvld`=1 continuously: one push per cycle until full.
- Stall of `rd_prdy` for N cycles: the pipeline freezes with no data loss or duplication, then resumes at full rate.
- Every state register updates on `clk` rising edge. Only `rst` acts asynchronously.

## Test plan
- Single entry: reset, push 0x1_2345 at edge 0 → `ram_re` at edge 1, `ram_ore` at edge 2, `rd_pvld`=1 with `rd_pd`=0x1_2345 from edge 2. `occupancy` goes 1 → 0 after pop.
- Fill: push 257 entries with `rd_prdy`=0 → `wr_prdy` falls after entry 257. `occupancy`=257, `used`=256. Then pop all → data in order, `wr_prdy` rises the cycle after the first `ram_ore`.
- Wrap streaming: 1000 back-to-back pushes with `rd_prdy`=1 → one pop per cycle after 2-cycle fill. In-order data across 3 pointer wraps; `occupancy` ≤ 3.
- Backpressure: stream with `rd_prdy` random 50% → scoreboard matches. `rd_pd` stable while stalled; `ram_re`=0 whenever `p1_vld` && !`ram_ore`.
- Full boundary: at `used`=256, pop and push offered in the same cycle → pop succeeds, push is refused that cycle and accepted the next.
- Async reset: assert `rst` mid-stream with 100 entries queued → `rd_pvld`=0 and `occupancy`=0 immediately, without waiting for `clk`. After release, a new push of 0xABC returns 0xABC with no stale data.

Source files
------------

// File: rtl/nv_ram_rwsp_fifo_ctrl.sv
// Push/pop FIFO controller for an external RAM with a two-stage read port
// (re latches the address, ore latches the data). Capacity is DEPTH+1.
module nv_ram_rwsp_fifo_ctrl #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 257
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW:0]   occupancy,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_di,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    output logic          ram_ore,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd,
    output logic [31:0]   ram_pwrbus_ram_pd
);
    localparam logic [AW:0]   LP_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_used;
    logic [AW:0]   r_avail;
    logic          r_p1_vld;
    logic          r_out_vld;

    logic          w_accept;
    logic          w_issue;
    logic          w_advance;
    logic [AW:0]   w_accept_inc;
    logic [AW:0]   w_advance_dec;
    logic [AW:0]   w_issue_dec;

    // Handshake on both sides: a beat transfers at a rising clk edge where
    // valid && ready; the sender holds valid and payload steady until then,
    // and ready never depends combinationally on the other side's handshake.
    assign wr_prdy   = !rst && (r_used != LP_DEPTH);
    assign w_accept  = wr_pvld && wr_prdy;

    // A held address register keeps M[ra] stable, so issue waits for advance.
    assign w_advance = r_p1_vld && (!r_out_vld || rd_prdy);
    assign w_issue   = (r_avail != '0) && (!r_p1_vld || w_advance);

    assign w_accept_inc  = {{AW{1'b0}}, w_accept};
    assign w_advance_dec = {{AW{1'b0}}, w_advance};
    assign w_issue_dec   = {{AW{1'b0}}, w_issue};

    assign ram_we  = w_accept;
    assign ram_wa  = r_wr_ptr;
    assign ram_di  = wr_pd;
    assign ram_re  = w_issue;
    assign ram_ra  = r_rd_ptr;
    assign ram_ore = w_advance;

    assign rd_pvld   = r_out_vld;
    assign rd_pd     = ram_dout;
    assign occupancy = r_used + {{AW{1'b0}}, r_out_vld};

    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_used    <= '0;
            r_avail   <= '0;
            r_p1_vld  <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            // A slot is only reusable once its data sits in the output register.
            r_used    <= r_used + w_accept_inc - w_advance_dec;
            r_avail   <= r_avail + w_accept_inc - w_issue_dec;
            r_p1_vld  <= w_issue || (r_p1_vld && !w_advance);
            r_out_vld <= w_advance || (r_out_vld && !rd_prdy);
        end
    end

endmodule

// File: tb/tb_nv_ram_rwsp_fifo_ctrl.sv
// Directed bench for nv_ram_rwsp_fifo_ctrl with a behavioural two-stage-read RAM.
// Inputs change on the falling edge; outputs are sampled 1ns later.
`timescale 1ns/1ps
module tb_nv_ram_rwsp_fifo_ctrl;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int DW    = 257;
    localparam logic [DW-1:0] PD_SINGLE = 257'h1_2345;
    localparam logic [DW-1:0] PD_ABC    = 257'hABC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_pvld = 1'b0;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd = '0;
    logic          rd_pvld;
    logic          rd_prdy = 1'b0;
    logic [DW-1:0] rd_pd;
    logic [AW:0]   occupancy;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_di;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic          ram_ore;
    logic [DW-1:0] ram_dout;
    logic [31:0]   pwrbus_ram_pd = 32'hDEAD_BEEF;
    logic [31:0]   ram_pwrbus_ram_pd;

    int errors = 0;
    int checks = 0;
    int seq    = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_v;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- external RAM model ----------------
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [AW-1:0] ra_q;
    logic [DW-1:0] dout_q;
    always @(posedge clk) begin
        if (ram_we)  mem[ram_wa] <= ram_di;
        if (ram_re)  ra_q <= ram_ra;
        if (ram_ore) dout_q <= mem[ra_q];
    end
    assign ram_dout = dout_q;

    nv_ram_rwsp_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
        .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
        .occupancy(occupancy),
        .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
        .ram_re(ram_re), .ram_ra(ram_ra), .ram_ore(ram_ore),
        .ram_dout(ram_dout),
        .pwrbus_ram_pd(pwrbus_ram_pd), .ram_pwrbus_ram_pd(ram_pwrbus_ram_pd)
    );

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] w;
        w = i ^ 32'hA5C3_0000;
        return {w[0], {8{w}}};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_until_full(output int n);
        n = 0;
        for (int c = 0; c < 280; c++) begin
            @(negedge clk);
            rd_prdy = 1'b0;
            wr_pvld = 1'b1;
            wr_pd   = pat(seq);
            #1;
            if (wr_prdy) begin
                exp_q.push_back(wr_pd);
                seq++;
                n++;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        wr_pvld = 1'b1;
        rd_prdy = 1'b1;
        #1;
        checks++; if (wr_prdy !== 1'b0) begin errors++; $display("FAIL reset_wr_prdy: got %b expected 0", wr_prdy); end
        checks++; if (rd_pvld !== 1'b0) begin errors++; $display("FAIL reset_rd_pvld: got %b expected 0", rd_pvld); end
        checks++; if (occupancy !== 9'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        checks++; if ({ram_we, ram_re, ram_ore} !== 3'b000) begin errors++; $display("FAIL reset_ram_ctl: got we/re/ore=%b expected 000", {ram_we, ram_re, ram_ore}); end
        checks++; if (ram_pwrbus_ram_pd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reset_pwrbus: got %h expected deadbeef", ram_pwrbus_ram_pd); end
        @(negedge clk);
        rst = 1'b0;
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        pwrbus_ram_pd = 32'h0123_4567;
        #1;
        checks++; if (wr_prdy !== 1'b1) begin errors++; $display("FAIL post_reset_wr_prdy: got %b expected 1", wr_prdy); end
        checks++; if (ram_pwrbus_ram_pd !== 32'h0123_4567) begin errors++; $display("FAIL pwrbus_pass: got %h expected 01234567", ram_pwrbus_ram_pd); end
    endtask

    task automatic test_single();
        @(negedge clk);
        wr_pvld = 1'b1;
        wr_pd   = PD_SINGLE;
        #1;
        checks++; if ({ram_we, ram_re} !== 2'b10 || ram_wa !== 8'd0 || ram_di !== PD_SINGLE) begin
            errors++; $display("FAIL single_w0: got we=%b re=%b wa=%0d expected we=1 re=0 wa=0", ram_we, ram_re, ram_wa); end
        @(negedge clk);
        wr_pvld = 1'b0;
        #1;
        checks++; if (ram_re !== 1'b1 || ram_ra !== 8'd0 || ram_ore !== 1'b0) begin
            errors++; $display("FAIL single_w1: got re=%b ra=%0d ore=%b expected re=1 ra=0 ore=0", ram_re, ram_ra, ram_ore); end
        checks++; if (occupancy !== 9'd1 || rd_pvld !== 1'b0) begin
            errors++; $display("FAIL single_occ1: got occ=%0d pvld=%b expected occ=1 pvld=0", occupancy, rd_pvld); end
        @(negedge clk);
        #1;
        checks++; if (ram_ore !== 1'b1 || ram_re !== 1'b0 || rd_pvld !== 1'b0) begin
            errors++; $display("FAIL single_w2: got ore=%b re=%b pvld=%b expected ore=1 re=0 pvld=0", ram_ore, ram_re, rd_pvld); end
        @(negedge clk);
        #1;
        checks++; if (rd_pvld !== 1'b1 || rd_pd !== PD_SINGLE || occupancy !== 9'd1) begin
            errors++; $display("FAIL single_data: got pvld=%b pd=%h occ=%0d expected pvld=1 pd=12345 occ=1", rd_pvld, rd_pd, occupancy); end
        rd_prdy = 1'b1;
        @(negedge clk);
        rd_prdy = 1'b0;
        #1;
        checks++; if (rd_pvld !== 1'b0 || occupancy !== 9'd0) begin
            errors++; $display("FAIL single_pop: got pvld=%b occ=%0d expected pvld=0 occ=0", rd_pvld, occupancy); end
    endtask

    task automatic test_fill();
        int n;
        push_until_full(n);
        checks++; if (n !== 257) begin errors++; $display("FAIL fill_count: got %0d accepted expected 257", n); end
        @(negedge clk);
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        #1;
        checks++; if (occupancy !== 9'd257 || wr_prdy !== 1'b0 || rd_pvld !== 1'b1) begin
            errors++; $display("FAIL fill_full: got occ=%0d wr_prdy=%b pvld=%b expected 257/0/1", occupancy, wr_prdy, rd_pvld); end
        checks++; if (ram_re !== 1'b0 || ram_ore !== 1'b0) begin
            errors++; $display("FAIL fill_frozen: got re=%b ore=%b expected 0/0", ram_re, ram_ore); end
        rd_prdy = 1'b1;
        #1;
        checks++; if (ram_ore !== 1'b1 || wr_prdy !== 1'b0) begin
            errors++; $display("FAIL fill_first_free: got ore=%b wr_prdy=%b expected 1/0", ram_ore, wr_prdy); end
        for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
            if (c > 0) begin
                @(negedge clk);
                rd_prdy = 1'b1;
                #1;
            end
            if (c == 1) begin
                checks++; if (wr_prdy !== 1'b1) begin errors++; $display("FAIL fill_wr_prdy_rise: got %b expected 1", wr_prdy); end
            end
            if (rd_pvld) begin
                exp_v = exp_q.pop_front();
                checks++; if (rd_pd !== exp_v) begin errors++; $display("FAIL fill_data: got %h expected %h", rd_pd, exp_v); end
            end
        end
        @(negedge clk);
        rd_prdy = 1'b0;
        #1;
        checks++; if (exp_q.size() != 0 || occupancy !== 9'd0 || rd_pvld !== 1'b0) begin
            errors++; $display("FAIL fill_drain: got left=%0d occ=%0d pvld=%b expected 0/0/0", exp_q.size(), occupancy, rd_pvld); end
    endtask

    task automatic test_back_to_back();
        int n, pops, max_occ, last_pop;
        n = 0; pops = 0; max_occ = 0; last_pop = -1;
        for (int c = 0; c < 1100 && pops < 1000; c++) begin
            @(negedge clk);
            rd_prdy = 1'b1;
            if (n < 1000) begin
                wr_pvld = 1'b1;
                wr_pd   = pat(seq);
            end else begin
                wr_pvld = 1'b0;
            end
            #1;
            if (wr_pvld && wr_prdy) begin
                exp_q.push_back(wr_pd);
                seq++;
                n++;
            end
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            if (rd_pvld) begin
                exp_v = exp_q.pop_front();
                checks++; if (rd_pd !== exp_v) begin errors++; $display("FAIL b2b_data: got %h expected %h", rd_pd, exp_v); end
                pops++;
                last_pop = c;
            end
        end
        checks++; if (pops !== 1000) begin errors++; $display("FAIL b2b_pops: got %0d expected 1000", pops); end
        checks++; if (last_pop !== 1002) begin errors++; $display("FAIL b2b_rate: got last pop window %0d expected 1002", last_pop); end
        checks++; if (max_occ > 3) begin errors++; $display("FAIL b2b_occ: got max %0d expected at most 3", max_occ); end
    endtask

    task automatic test_backpressure();
        int n, pops;
        logic prev_stall;
        logic [DW-1:0] prev_pd;
        n = 0; pops = 0; prev_stall = 1'b0; prev_pd = '0;
        for (int c = 0; c < 3000 && pops < 300; c++) begin
            @(negedge clk);
            rd_prdy = 1'($urandom_range(0, 1));
            if (n < 300) begin
                wr_pvld = ($urandom_range(0, 3) != 0);
                wr_pd   = pat(seq);
            end else begin
                wr_pvld = 1'b0;
            end
            #1;
            if (prev_stall) begin
                checks++; if (rd_pvld !== 1'b1 || rd_pd !== prev_pd) begin
                    errors++; $display("FAIL bp_hold: got pvld=%b pd=%h expected 1 %h", rd_pvld, rd_pd, prev_pd); end
            end
            if (rd_pvld && !rd_prdy) begin
                checks++; if (ram_ore !== 1'b0) begin errors++; $display("FAIL bp_ore_stall: got ore=%b expected 0", ram_ore); end
            end
            if (wr_pvld && wr_prdy) begin
                exp_q.push_back(wr_pd);
                seq++;
                n++;
            end
            if (rd_pvld && rd_prdy) begin
                exp_v = exp_q.pop_front();
                checks++; if (rd_pd !== exp_v) begin errors++; $display("FAIL bp_data: got %h expected %h", rd_pd, exp_v); end
                pops++;
            end
            prev_stall = rd_pvld && !rd_prdy;
            prev_pd    = rd_pd;
        end
        checks++; if (pops !== 300) begin errors++; $display("FAIL bp_pops: got %0d expected 300", pops); end
    endtask

    task automatic test_full_boundary();
        int n;
        push_until_full(n);
        checks++; if (n !== 257) begin errors++; $display("FAIL fb_count: got %0d accepted expected 257", n); end
        @(negedge clk);
        wr_pvld = 1'b1;
        wr_pd   = pat(seq);
        rd_prdy = 1'b1;
        #1;
        checks++; if (wr_prdy !== 1'b0 || ram_we !== 1'b0 || ram_ore !== 1'b1) begin
            errors++; $display("FAIL fb_same_cycle: got wr_prdy=%b we=%b ore=%b expected 0/0/1", wr_prdy, ram_we, ram_ore); end
        exp_v = exp_q.pop_front();
        checks++; if (rd_pvld !== 1'b1 || rd_pd !== exp_v) begin errors++; $display("FAIL fb_pop: got pvld=%b pd=%h expected 1 %h", rd_pvld, rd_pd, exp_v); end
        @(negedge clk);
        rd_prdy = 1'b0;
        #1;
        checks++; if (wr_prdy !== 1'b1 || ram_we !== 1'b1) begin
            errors++; $display("FAIL fb_next_cycle: got wr_prdy=%b we=%b expected 1/1", wr_prdy, ram_we); end
        exp_q.push_back(wr_pd);
        seq++;
        @(negedge clk);
        wr_pvld = 1'b0;
        #1;
        checks++; if (occupancy !== 9'd257 || wr_prdy !== 1'b0) begin
            errors++; $display("FAIL fb_refull: got occ=%0d wr_prdy=%b expected 257/0", occupancy, wr_prdy); end
        for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            rd_prdy = 1'b1;
            #1;
            if (rd_pvld) begin
                exp_v = exp_q.pop_front();
                checks++; if (rd_pd !== exp_v) begin errors++; $display("FAIL fb_data: got %h expected %h", rd_pd, exp_v); end
            end
        end
        @(negedge clk);
        rd_prdy = 1'b0;
        #1;
        checks++; if (exp_q.size() != 0 || occupancy !== 9'd0) begin
            errors++; $display("FAIL fb_drain: got left=%0d occ=%0d expected 0/0", exp_q.size(), occupancy); end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        for (int c = 0; c < 150 && n < 100; c++) begin
            @(negedge clk);
            rd_prdy = 1'b0;
            wr_pvld = 1'b1;
            wr_pd   = pat(seq);
            #1;
            if (wr_prdy) begin
                seq++;
                n++;
            end
        end
        @(negedge clk);
        wr_pvld = 1'b0;
        #1;
        checks++; if (occupancy !== 9'd100 || rd_pvld !== 1'b1) begin
            errors++; $display("FAIL ar_queued: got occ=%0d pvld=%b expected 100/1", occupancy, rd_pvld); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rd_pvld !== 1'b0 || occupancy !== 9'd0 || wr_prdy !== 1'b0) begin
            errors++; $display("FAIL ar_immediate: got pvld=%b occ=%0d wr_prdy=%b expected 0/0/0", rd_pvld, occupancy, wr_prdy); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wr_pvld = 1'b1;
        wr_pd   = PD_ABC;
        #1;
        checks++; if (ram_we !== 1'b1 || ram_wa !== 8'd0 || ram_re !== 1'b0) begin
            errors++; $display("FAIL ar_push: got we=%b wa=%0d re=%b expected 1/0/0", ram_we, ram_wa, ram_re); end
        @(negedge clk);
        wr_pvld = 1'b0;
        #1;
        checks++; if (ram_re !== 1'b1 || ram_ra !== 8'd0 || rd_pvld !== 1'b0) begin
            errors++; $display("FAIL ar_issue: got re=%b ra=%0d pvld=%b expected 1/0/0", ram_re, ram_ra, rd_pvld); end
        @(negedge clk);
        #1;
        checks++; if (ram_ore !== 1'b1 || rd_pvld !== 1'b0) begin
            errors++; $display("FAIL ar_advance: got ore=%b pvld=%b expected 1/0", ram_ore, rd_pvld); end
        @(negedge clk);
        #1;
        checks++; if (rd_pvld !== 1'b1 || rd_pd !== PD_ABC) begin
            errors++; $display("FAIL ar_data: got pvld=%b pd=%h expected 1 abc", rd_pvld, rd_pd); end
        rd_prdy = 1'b1;
        @(negedge clk);
        rd_prdy = 1'b0;
        #1;
        checks++; if (rd_pvld !== 1'b0 || occupancy !== 9'd0) begin
            errors++; $display("FAIL ar_empty: got pvld=%b occ=%0d expected 0/0", rd_pvld, occupancy); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_backpressure();
        test_full_boundary();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
